hazard_stall_unit: RTL and testbench

// Pipeline hazard controller for the 5-stage RV32 core; the producer side of the EX-stage forwarding unit.

---
 rtl/hazard_stall_unit_if.sv | 32 +++
 rtl/hazard_stall_unit.sv | 113 +++++++++++
 tb/tb_hazard_stall_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline and the hazard/stall controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      id_instruction;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ack;
    logic             stall_pc;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             stall_all;
    logic             ignore_fwd_ex;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_instruction, id_ex_mem_read, id_ex_rd, ex_branch_taken, dmem_req, dmem_ack,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_all, ignore_fwd_ex,
               mem_error, stall_cycles
    );

    modport slave (
        input  id_instruction, id_ex_mem_read, id_ex_rd, ex_branch_taken, dmem_req, dmem_ack,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_all, ignore_fwd_ex,
               mem_error, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use stalls, branch flushes,
// multi-cycle data-memory freezes with timeout, and the EX-bubble flag for forwarding.
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_unit_if.slave hz
);
    localparam int unsigned    WaitW    = $clog2(MEM_TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             ignore_fwd_q, ignore_fwd_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, load_use;
    logic       timeout_hit, stall_all;
    logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex;

    assign opcode = hz.id_instruction[6:0];
    assign rs1    = hz.id_instruction[19:15];
    assign rs2    = hz.id_instruction[24:20];

    always_comb begin
        rs1_used = !(opcode inside {OpLui, OpAuipc, OpJal});
        rs2_used = opcode inside {OpReg, OpStore, OpBr};
        load_use = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                   ((rs1_used && (hz.id_ex_rd == rs1)) || (rs2_used && (hz.id_ex_rd == rs2)));
    end

    // Forced release on the last allowed wait cycle keeps a hung memory from locking the core.
    assign timeout_hit = (state_q == StMemWait) && (wait_cnt_q == WaitLast) && !hz.dmem_ack;
    assign stall_all   = hz.dmem_req && !hz.dmem_ack && !timeout_hit;

    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (stall_all) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
        end else if (hz.ex_branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            StRun: begin
                if (stall_all) state_d = StMemWait;
            end
            StMemWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (hz.dmem_ack || timeout_hit || !hz.dmem_req) state_d = StRun;
            end
        endcase
    end

    always_comb begin
        ignore_fwd_d   = stall_all ? ignore_fwd_q : flush_id_ex;
        mem_error_d    = mem_error_q | timeout_hit;
        stall_cycles_d = stall_cycles_q;
        if (stall_pc && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            ignore_fwd_q   <= 1'b1;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            ignore_fwd_q   <= ignore_fwd_d;
            mem_error_q    <= mem_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.stall_pc      = stall_pc;
    assign hz.stall_if_id   = stall_if_id;
    assign hz.flush_if_id   = flush_if_id;
    assign hz.flush_id_ex   = flush_id_ex;
    assign hz.stall_all     = stall_all;
    assign hz.ignore_fwd_ex = ignore_fwd_q;
    assign hz.mem_error     = mem_error_q;
    assign hz.stall_cycles  = stall_cycles_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboarded directed bench for hazard_stall_unit; expected outputs are queued per vector
// and checked by an independent monitor on the falling edge.
module tb_hazard_stall_unit;
    localparam int unsigned CntW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CntW)) hz_if ();

    hazard_stall_unit #(
        .MEM_TIMEOUT(16),
        .CNT_W      (CntW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz_if.slave)
    );

    typedef struct {
        string            name;
        logic [4:0]       comb;  // {stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_all}
        logic             ign;
        logic             merr;
        logic [CntW-1:0]  cnt;
    } exp_t;

    exp_t            sb[$];
    int              n_vec = 0;
    int              n_bad = 0;
    logic [CntW-1:0] exp_cnt = '0;

    localparam logic [4:0] None  = 5'b00000;
    localparam logic [4:0] LdUse = 5'b11010;
    localparam logic [4:0] Brnch = 5'b00110;
    localparam logic [4:0] Frz   = 5'b11001;

    localparam logic [31:0] Nop      = 32'h0000_0013;
    localparam logic [31:0] AddX5X7  = {7'b0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] AddX0X0  = {7'b0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LuiX5    = {20'h00028, 5'd5, 7'b0110111};  // imm bits alias rs1=5
    localparam logic [31:0] SwX5     = {7'b0, 5'd5, 5'd8, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] AddiRs2f = {12'd5, 5'd8, 3'b000, 5'd6, 7'b0010011};  // rs2 field=5

    task automatic push(input string name, input logic [4:0] comb, input logic ign,
                        input logic merr);
        exp_t e;
        e.name = name;
        e.comb = comb;
        e.ign  = ign;
        e.merr = merr;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (comb[4]) exp_cnt = (exp_cnt == '1) ? exp_cnt : exp_cnt + 1'b1;
    endtask

    task automatic vec(input string name, input logic [31:0] instr, input logic mr,
                       input logic [4:0] rd, input logic br, input logic req, input logic ack,
                       input logic [4:0] comb, input logic ign, input logic merr);
        @(posedge clk);
        #1;
        hz_if.id_instruction  = instr;
        hz_if.id_ex_mem_read  = mr;
        hz_if.id_ex_rd        = rd;
        hz_if.ex_branch_taken = br;
        hz_if.dmem_req        = req;
        hz_if.dmem_ack        = ack;
        push(name, comb, ign, merr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        hz_if.id_instruction  = Nop;
        hz_if.id_ex_mem_read  = 1'b0;
        hz_if.id_ex_rd        = 5'd0;
        hz_if.ex_branch_taken = 1'b0;
        hz_if.dmem_req        = 1'b0;
        hz_if.dmem_ack        = 1'b0;
        rst_n                 = 1'b0;
        exp_cnt               = '0;
        push("reset", None, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one vector is live per cycle, so each falling edge retires one entry.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                logic [7+CntW-1:0] act, req;
                e   = sb.pop_front();
                act = {hz_if.stall_pc, hz_if.stall_if_id, hz_if.flush_if_id, hz_if.flush_id_ex,
                       hz_if.stall_all, hz_if.ignore_fwd_ex, hz_if.mem_error, hz_if.stall_cycles};
                req = {e.comb, e.ign, e.merr, e.cnt};
                n_vec++;
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got {comb,ign,merr,cnt}=%b required %b at %0t",
                             e.name, act, req, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hz_if.id_instruction  = Nop;
        hz_if.id_ex_mem_read  = 1'b0;
        hz_if.id_ex_rd        = 5'd0;
        hz_if.ex_branch_taken = 1'b0;
        hz_if.dmem_req        = 1'b0;
        hz_if.dmem_ack        = 1'b0;
        do_reset();

        vec("idle",         Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("ld_use_rs1",   AddX5X7,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LdUse, 1'b0, 1'b0);
        vec("bubble",       AddX5X7,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b1, 1'b0);
        vec("post_bubble",  Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("lui_no_rs1",   LuiX5,    1'b1, 5'd5, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("rs_x0",        AddX0X0,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("rd_x0",        AddX0X0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("ld_use_rs2",   SwX5,     1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LdUse, 1'b0, 1'b0);
        vec("itype_no_rs2", AddiRs2f, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, None,  1'b1, 1'b0);
        vec("branch_wins",  AddX5X7,  1'b1, 5'd5, 1'b1, 1'b0, 1'b0, Brnch, 1'b0, 1'b0);
        vec("ld_use_pre",   AddX5X7,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LdUse, 1'b1, 1'b0);
        // Freeze entered while ignore_fwd_ex=1; it must hold through the ack cycle.
        vec("mem_wait1",    Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b1, 1'b0);
        vec("mem_wait2",    Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b1, 1'b0);
        vec("mem_wait3",    Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b1, 1'b0);
        vec("mem_ack",      Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b1, None,  1'b1, 1'b0);
        vec("after_ack",    Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);

        for (int i = 0; i < 16; i++)
            vec("timeout_frz", Nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz, 1'b0, 1'b0);
        vec("timeout_rel",  Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, None,  1'b0, 1'b0);
        vec("merr_set",     Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b1);
        vec("merr_sticky",  Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b1);

        // Second timeout drives the 5-bit stall counter into saturation.
        for (int i = 0; i < 16; i++)
            vec("sat_frz", Nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz, 1'b0, 1'b1);
        vec("sat_rel",      Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, None,  1'b0, 1'b1);
        vec("sat_hold",     Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b1);

        vec("pre_rst_frz1", Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b0, 1'b1);
        vec("pre_rst_frz2", Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b0, 1'b1);
        do_reset();
        vec("post_rst",     Nop,      1'b0, 5'd0, 1'b0, 1'b0, 1'b0, None,  1'b0, 1'b0);
        vec("post_rst_frz", Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Frz,   1'b0, 1'b0);
        vec("post_rst_ack", Nop,      1'b0, 5'd0, 1'b0, 1'b1, 1'b1, None,  1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
